// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and Johnson-code helper functions
package johnson_pkg;

  typedef enum logic {
    DIR_REV = 1'b0,
    DIR_FWD = 1'b1
  } johnson_dir_e;

  localparam int JOHNSON_MAX_W = 32;

  function automatic int johnson_idx_w(input int width);
    return $clog2(2 * width);
  endfunction

  // Codes are zero-extended to JOHNSON_MAX_W; only the low 'width' bits take part.
  function automatic logic johnson_legal(input logic [JOHNSON_MAX_W-1:0] q, input int width);
    int diffs = 0;
    for (int i = 0; i < JOHNSON_MAX_W - 1; i++) begin
      if ((i < width - 1) && (q[i] != q[i+1])) diffs++;
    end
    return (diffs <= 1);
  endfunction

  function automatic logic [6:0] johnson_index(input logic [JOHNSON_MAX_W-1:0] q, input int width);
    logic [6:0] pop = '0;
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      if (i < width) pop = pop + 7'(q[i]);
    end
    if (!johnson_legal(q, width)) return '0;
    if ((q == '0) || q[0]) return pop;
    return 7'(2 * width) - pop;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational Johnson code to position index and illegal flag
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = johnson_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] q_i,
  output logic [IDX_W-1:0] state_idx_o,
  output logic             illegal_o
);

  logic [JOHNSON_MAX_W-1:0] q_ext;

  assign q_ext       = JOHNSON_MAX_W'(q_i);
  assign illegal_o   = !johnson_legal(q_ext, WIDTH);
  assign state_idx_o = IDX_W'(johnson_index(q_ext, WIDTH));

endmodule

// File: rtl/johnson_counter_param.sv
// rtl/johnson_counter_param.sv - parametrised Johnson counter; optional JOHNSON_SELF_CORRECT_EN
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = johnson_idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] state_idx,
  output logic             wrap,
  output logic             illegal
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] shift_fwd, shift_rev, shifted;

  assign shift_fwd = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
  assign shift_rev = {~q_q[0], q_q[WIDTH-1:1]};
  assign shifted   = (dir == DIR_FWD) ? shift_fwd : shift_rev;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .q_i         (q_q),
    .state_idx_o (state_idx),
    .illegal_o   (illegal)
  );

  // Only a shift landing on all-zeros wraps; loads and corrections never do.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_val;
`ifdef JOHNSON_SELF_CORRECT_EN
    end else if (illegal) begin
      q_d = '0;
`endif
    end else if (en) begin
      q_d    = shifted;
      wrap_d = (shifted == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule
